rv_mem_arbiter: RTL
===================

// Module: rv_mem_arbiter
// PURPOSE
//  Shares the single-port unified memory of the multicycle RISC-V core between two requesters.
//  Port 0 is the core control/datapath (instruction fetch and LW/SW); port 1 is the external program loader/debug port.
//  Arbitrates and serialises accesses, and inserts memory wait states. Returns a one-cycle ack per completed access.
//  The core FSM holds its current state (FETCH, LW_MEM, SW_MEM) until ack.
// PARAMETERS
//  MEM_LAT   1   cycles mem_en/addr are held before read data is valid or a write commits (>=1)
//  FIXED_PRI 0   0 = round-robin between ports; 1 = port 0 (core) always wins ties
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  req        in   2   per-port access request; bit0 core, bit1 loader
//  we         in   2   per-port write enable (1 = store)
//  addr0      in   32  core byte address
//  wdata0     in   32  core write data
//  addr1      in   32  loader byte address
//  wdata1     in   32  loader write data
//  ack        out  2   one-cycle pulse, access of that port complete
//  rdata      out  32  registered read data, valid in ack cycle, held until next ack
//  gnt        out  2   one-hot owner of the current access; 0 when IDLE
//  busy       out  1   1 while state != IDLE
//  mem_en     out  1   memory access enable
//  mem_we     out  1   memory write enable
//  mem_addr   out  32  memory address
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid in last ACCESS cycle
// BEHAVIOUR
//  Reset: state=IDLE; ack, gnt, busy, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0; last_gnt = port1.
//   With last_gnt = port1, the core wins the first tie.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE:
//   - req==0: stay.
//   - Otherwise select winner, then go ACCESS with cnt = MEM_LAT-1.
//     Latch winner's addr/wdata/we into mem_addr/mem_wdata/mem_we; set gnt.
//   - Winner with FIXED_PRI=1: port 0 if req[0], else port 1.
//   - Winner with FIXED_PRI=0: a single requester wins.
//     If both request, the port != last_gnt wins; last_gnt updates on grant.
//  ACCESS:
//   - mem_en=1 and mem_addr/mem_we/mem_wdata stable for exactly MEM_LAT cycles.
//   - cnt decrements each cycle.
//   - At cnt==0: rdata <= mem_rdata (reads only; writes leave rdata unchanged), go DONE.
//   - A write commits in memory on the final ACCESS edge.
//  DONE:
//   - ack[gnt]=1 for this single cycle; mem_en=0.
//   - Next state IDLE; gnt cleared on leaving DONE.
//  Latency: req sampled in IDLE at cycle T -> ack at cycle T+MEM_LAT+1.
//   Minimum spacing between grants is MEM_LAT+2 cycles.
//  Requester protocol:
//   - Hold req, we, addr, wdata stable until ack.
//   - Deassert req, or present a new request, in the cycle after ack.
//   - Inputs are sampled only in IDLE; changes during ACCESS/DONE have no effect.
//  Request dropped mid-access: access still completes and ack still pulses (no abort).
//  Simultaneous new request by acked port in DONE: ignored; re-arbitrated in following IDLE cycle.
//  Round-robin guarantee: with both ports requesting continuously, grants strictly alternate.
//   No port waits more than one full access.
//  Reset mid-ACCESS/DONE:
//   - Next cycle is IDLE with all outputs at reset values.
//   - No ack for the aborted access; memory write is not guaranteed to have committed.
//  cnt width $clog2(MEM_LAT+1); MEM_LAT=1 gives a single ACCESS cycle.
//  ack and gnt never have more than one bit set.
// TESTING
//  1. MEM_LAT=1, core read only: req=01, addr0=0x40, mem holds 0xDEADBEEF -> ack=01 at T+2, rdata=0xDEADBEEF.
//  2. MEM_LAT=3, loader write: req=10, we=10, addr1=0x100, wdata1=0x1234 -> mem_en high 3 cycles, ack=10 at T+4, mem[0x100]=0x1234.
//  3. FIXED_PRI=0, both requesting continuously from reset -> grant order 0,1,0,1; each ack one cycle.
//  4. FIXED_PRI=1, both requesting continuously -> port 0 granted every time, port 1 never acked.
//  5. rst asserted in 2nd ACCESS cycle (MEM_LAT=3) -> next cycle IDLE, mem_en=0, ack stays 0, then a fresh req is served normally.
//  6. req[0] dropped mid-ACCESS -> ack[0] still pulses at T+MEM_LAT+1; no spurious second grant.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// Two-port arbiter in front of the single-port unified memory of the multicycle core.
// Port 0 is the core (fetch, LW/SW), port 1 is the program loader / debug port.
// Each access is serialised as IDLE -> ACCESS (MEM_LAT cycles) -> DONE (one-cycle ack).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access in flight; requests are sampled and arbitrated here
// ACCESS | mem_en high, address/data/we held; cnt counts down to 0
// DONE   | ack pulses for the granted port; gnt clears on exit
module rv_mem_arbiter #(
  parameter int MEM_LAT   = 1,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_gnt;  // 1 = port 1 was granted last
  logic          win;       // 1 = port 1 wins this arbitration

  // Winner selection: fixed priority to the core, or round-robin on a tie
  always_comb begin
    win = 1'b0;
    if (FIXED_PRI) begin
      win = ~req[0];
    end else if (req == 2'b11) begin
      win = ~last_gnt;
    end else begin
      win = req[1];
    end
  end

  // Access sequencing, grant/latch of the winner's request, read data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      gnt       <= 2'b00;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            state     <= S_ACCESS;
            cnt       <= CNT_LOAD;
            last_gnt  <= win;
            gnt       <= win ? 2'b10 : 2'b01;
            mem_we    <= win ? we[1] : we[0];
            mem_addr  <= win ? addr1 : addr0;
            mem_wdata <= win ? wdata1 : wdata0;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
        end
        default: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  // Decoded status: ack is the grant qualified by DONE, so it is one-hot or zero
  always_comb begin
    ack    = (state == S_DONE) ? gnt : 2'b00;
    mem_en = (state == S_ACCESS);
    busy   = (state != S_IDLE);
  end

endmodule
